inbuf_sched: RTL

Feed scheduler for the systolic array's bank of `INBUF` row buffers. Accepts one operand tile per command as a row-major word stream. Steers each word into the correct row buffer. Then issues skewed per-row read strobes so row `r` begins draining `r` cycles after row 0. It sits between the tile loader and the `INBUF` bank and is the only driver of the buffers' `write`, `din` and `read` pins.

---
 rtl/systola_pkg.sv | 5 +
 rtl/sched_skew_gen.sv | 18 +
 rtl/inbuf_sched.sv | 101 ++++++++++
 3 files changed

// File: rtl/systola_pkg.sv
// systola_pkg: shared types and defaults for the systolic-array feed schedulers.
package systola_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} sched_state_t;
    localparam int SYSTOLA_DW = 8;
endpackage

// File: rtl/sched_skew_gen.sv
// sched_skew_gen: combinational skewed read window; row r is active for klen cycles starting at t==r.
module sched_skew_gen #(
    parameter int ROWS = 4,
    parameter int CW = 4,
    parameter int TW = 4
) (
    input  logic [TW-1:0]   t,
    input  logic [CW-1:0]   klen,
    input  logic            en,
    output logic [ROWS-1:0] read
);
    // Compare in 32-bit int space so r+klen can never wrap.
    always_comb begin
        read = '0;
        for (int i = 0; i < ROWS; i++)
            read[i] = en && (int'(t) >= i) && (int'(t) < i + int'(klen));
    end
endmodule

// File: rtl/inbuf_sched.sv
// inbuf_sched: steers a row-major tile stream into the INBUF bank, then issues skewed per-row read strobes.
// Optional underrun checker (sticky err output) enabled by defining INBUF_SCHED_CHK_EN.
module inbuf_sched
    import systola_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int DEPTH = 8,
    parameter int DW = SYSTOLA_DW,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   len,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic [ROWS-1:0] buf_write,
    output logic [DW-1:0]   buf_din,
    output logic [ROWS-1:0] buf_read,
    input  logic [ROWS-1:0] buf_empty
`ifdef INBUF_SCHED_CHK_EN
    ,
    output logic            err
`endif
);
    localparam int TW = $clog2(DEPTH + ROWS);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;

    sched_state_t state, next_state;
    logic [CW-1:0] klen, col_cnt;
    logic [RW-1:0] row_cnt;
    logic [TW-1:0] t;
    logic hs, col_end, row_end, t_end, accept;

    assign accept  = state == IDLE && start && len != '0;
    assign hs      = state == LOAD && in_valid;
    assign col_end = col_cnt == klen - CW'(1);
    assign row_end = row_cnt == RW'(ROWS - 1);
    assign t_end   = t == TW'(klen) + TW'(ROWS - 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (accept) next_state = LOAD;
        else if (hs && col_end && row_end) next_state = DRAIN;
        else if (state == DRAIN && t_end) next_state = IDLE;
    end

    always_comb begin
        busy      = state != IDLE;
        in_ready  = state == LOAD;
        buf_write = hs ? ROWS'(1) << row_cnt : '0;
        buf_din   = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            klen    <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            t       <= '0;
            done    <= 1'b0;
        end else begin
            done <= state == DRAIN && t_end;
            t    <= state == DRAIN ? t + TW'(1) : '0;
            if (accept) begin
                klen    <= len > CW'(DEPTH) ? CW'(DEPTH) : len;
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (hs) begin
                col_cnt <= col_end ? '0 : col_cnt + CW'(1);
                row_cnt <= col_end ? row_cnt + RW'(1) : row_cnt;
            end
        end
    end

    sched_skew_gen #(.ROWS(ROWS), .CW(CW), .TW(TW)) skew (
        .t    (t),
        .klen (klen),
        .en   (state == DRAIN),
        .read (buf_read)
    );

`ifdef INBUF_SCHED_CHK_EN
    // Sticky until reset; read strobes only exist in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          err <= 1'b0;
        else if (|(buf_read & buf_empty)) err <= 1'b1;
    end
`else
    logic unused_empty;
    assign unused_empty = ^buf_empty;
`endif
endmodule
